ms13_master_responder: RTL and testbench
========================================

Name: ms13_master_responder

Overview:
- Peer stage directly on the master side of TestMasterSlave13.
- Captures every word that module publishes on its notify-qualified m_out. Buffers the words in a small FIFO and processes them in a 3-state section machine.
- Returns a derived value on the unsynchronised m_in input of TestMasterSlave13.
- Forwards a running accumulation downstream over a blocking notify/sync port.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- OFFSET, 1, signed 32-bit constant added to each word to form m_in.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low (asserted when 0).
- m_out  in  32  signed word from TestMasterSlave13.
- m_out_notify  in  1  m_out valid this cycle; must be accepted or counted as dropped, no backpressure.
- m_in  out  32  signed value fed back to TestMasterSlave13.m_in.
- res_out  out  32  signed running accumulation.
- res_out_notify  out  1  res_out valid, held until accepted.
- res_out_sync  in  1  downstream ready; transfer occurs when notify and sync are both 1 at a clock edge.
- drop_cnt  out  8  words lost to a full FIFO; saturates at 255.
- overflow  out  1  sticky; set on the first drop, cleared only by reset.

Behaviour:
- Reset (rst=0, asynchronous):
  - m_in=0, res_out=0, res_out_notify=0, drop_cnt=0, overflow=0.
  - acc=0, FIFO empty, pointers 0, section=SEC_IDLE.
- FIFO push: on an edge with m_out_notify=1 and (not full, or a pop occurs on the same edge), m_out is written.
  - Full with no pop: word discarded, drop_cnt increments (saturating), overflow <= 1.
  - Pointers wrap modulo DEPTH.
  - full/empty are derived from a DEPTH+1 range occupancy count.
- SEC_IDLE: if FIFO not empty, pop head into work register and go to SEC_CALC; else stay.
- SEC_CALC, one cycle:
  - acc <= acc + work.
  - m_in <= work + OFFSET.
  - res_out <= acc + work; res_out_notify <= 1.
  - Go to SEC_SEND.
- SEC_SEND: hold res_out and res_out_notify.
  - On an edge with res_out_sync=1: res_out_notify <= 0, go to SEC_IDLE.
  - res_out_sync while in IDLE or CALC is ignored.
- Arithmetic: signed 32-bit, two's-complement wrap on overflow (see optional feature).
- m_in holds its last value between updates.
- Latency, empty FIFO and machine idle:
  - notify sampled at edge E0.
  - Pop at E1.
  - m_in and res_out update, res_out_notify rises, at E2.
  - Earliest return to IDLE is E3 (sync held high).
  - Throughput: at most 1 word per 3 cycles, so bursts longer than DEPTH+1 at full rate drop words.
- Push and pop on the same edge when full: both take effect; occupancy unchanged; no drop.
- Reset mid-transfer: res_out_notify falls asynchronously; the in-flight word and all FIFO contents are lost, and no completion is reported.

Optional Feature:
- Macro: MS13_RESPONDER_SATURATE_EN.
- Defined: acc+work and work+OFFSET saturate to 32'h7FFFFFFF / 32'h80000000 instead of wrapping.
- Undefined: plain wrap-around.
- All other behaviour is identical.

Decomposition:
- Package ms13_responder_types holds:
  - enum Sections_resp {SEC_IDLE, SEC_CALC, SEC_SEND}.
  - Constants INT_MAX and INT_MIN.
  - A saturating-add function used under the macro.
- One sub-module, ms13_resp_fifo (parameter DEPTH): push, pop, data in/out, full, empty. The top instantiates it and keeps the section machine, accumulator and drop counter.

Test Plan:
- Reset then single word: m_out=5, notify for 1 cycle, res_out_sync=1 → at E2 m_in=6, res_out=5, notify=1; notify=0 after E3; drop_cnt=0.
- Three words 10, 20, 30 spaced 4 cycles apart, sync always 1 → res_out sequence 10, 30, 60; m_in sequence 11, 21, 31.
- Backpressure: sync=0 for 20 cycles while 6 words 1..6 arrive on consecutive cycles:
  - First word in SEND, next 4 in FIFO, 6th dropped: drop_cnt=1, overflow=1.
  - On release, res_out sequence 1, 3, 6, 10, 15.
- Wrap: words 32'h7FFFFFFF then 1 → res_out = 32'h7FFFFFFF then 32'h80000000. With MS13_RESPONDER_SATURATE_EN: 32'h7FFFFFFF twice, and m_in=32'h7FFFFFFF for the first word.
- Push with simultaneous pop when full: fill FIFO, then notify on the same cycle the IDLE state pops → no drop, occupancy stays DEPTH.
- Async reset while in SEND: assert rst mid-cycle → res_out_notify, m_in and drop_cnt immediately 0. After release, a new word 7 gives res_out=7 (acc restarted).

Source files
------------

// File: rtl/ms13_master_responder_pkg.sv
// Shared types and arithmetic helpers for the master-side responder of TestMasterSlave13.
package ms13_responder_types;

  typedef enum logic [1:0] {
    SEC_IDLE,
    SEC_CALC,
    SEC_SEND
  } Sections_resp;

  localparam logic signed [31:0] INT_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] INT_MIN = 32'sh8000_0000;

  // Overflow only when both operands share a sign and the result's sign differs.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
    logic signed [31:0] s;
    s = a + b;
    if ((a[31] == b[31]) && (s[31] != a[31]))
      return a[31] ? INT_MIN : INT_MAX;
    return s;
  endfunction

endpackage

// File: rtl/ms13_master_responder_fifo.sv
// Word buffer between m_out capture and the section machine; occupancy count spans 0..DEPTH.
module ms13_resp_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        full,
  output logic        empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign dout  = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ms13_master_responder.sv
// Master-side responder: buffers m_out words, feeds back m_in and streams a running sum.
// Optional saturating arithmetic when MS13_RESPONDER_SATURATE_EN is defined.
module ms13_master_responder
  import ms13_responder_types::*;
#(
  parameter int unsigned        DEPTH  = 4,
  parameter logic signed [31:0] OFFSET = 32'sd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m_out,
  input  logic        m_out_notify,
  output logic [31:0] m_in,
  output logic [31:0] res_out,
  output logic        res_out_notify,
  input  logic        res_out_sync,
  output logic [7:0]  drop_cnt,
  output logic        overflow
);
  Sections_resp sec;
  logic [31:0]  work;
  logic [31:0]  acc;
  logic [31:0]  sum;
  logic [31:0]  m_next;
  logic [31:0]  fifo_dout;
  logic         fifo_full;
  logic         fifo_empty;
  logic         push;
  logic         pop;
  logic         drop;

  // A pop on the same edge frees a slot, so a full FIFO can still accept the word.
  always_comb begin
    pop  = (sec == SEC_IDLE) && !fifo_empty;
    push = m_out_notify && (!fifo_full || pop);
    drop = m_out_notify && fifo_full && !pop;
  end

`ifdef MS13_RESPONDER_SATURATE_EN
  assign sum    = sat_add(acc, work);
  assign m_next = sat_add(work, OFFSET);
`else
  assign sum    = acc + work;
  assign m_next = work + OFFSET;
`endif

  ms13_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (m_out),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec            <= SEC_IDLE;
      work           <= '0;
      acc            <= '0;
      m_in           <= '0;
      res_out        <= '0;
      res_out_notify <= 1'b0;
      drop_cnt       <= '0;
      overflow       <= 1'b0;
    end else begin
      if (drop) begin
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        overflow <= 1'b1;
      end
      case (sec)
        SEC_IDLE: begin
          if (!fifo_empty) begin
            work <= fifo_dout;
            sec  <= SEC_CALC;
          end
        end
        SEC_CALC: begin
          acc            <= sum;
          m_in           <= m_next;
          res_out        <= sum;
          res_out_notify <= 1'b1;
          sec            <= SEC_SEND;
        end
        SEC_SEND: begin
          if (res_out_sync) begin
            res_out_notify <= 1'b0;
            sec            <= SEC_IDLE;
          end
        end
        default: sec <= SEC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ms13_master_responder.sv
// Directed bench for ms13_master_responder (DEPTH=4, OFFSET=1).
module tb_ms13_master_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] m_out = '0;
  logic        m_out_notify = 1'b0;
  logic [31:0] m_in;
  logic [31:0] res_out;
  logic        res_out_notify;
  logic        res_out_sync = 1'b0;
  logic [7:0]  drop_cnt;
  logic        overflow;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned fails  = 0;

  always #5 clk = ~clk;

  ms13_master_responder #(.DEPTH(4), .OFFSET(32'sd1)) dut (
    .clk            (clk),
    .rst            (rst),
    .m_out          (m_out),
    .m_out_notify   (m_out_notify),
    .m_in           (m_in),
    .res_out        (res_out),
    .res_out_notify (res_out_notify),
    .res_out_sync   (res_out_sync),
    .drop_cnt       (drop_cnt),
    .overflow       (overflow)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    m_out = w;
    m_out_notify = 1'b1;
    tick();
    m_out_notify = 1'b0;
  endtask

  // Waits (bounded) for a result, checks it, then lets sync consume it.
  task automatic collect(input string tag, input logic [31:0] exp);
    int unsigned n = 0;
    while (res_out_notify !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_notify"}, {31'd0, res_out_notify}, 32'd1);
    chk(tag, res_out, exp);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_res [5];
    logic [31:0] exp_fill [5];

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_m_in", m_in, 32'd0);
    chk("rst_res_out", res_out, 32'd0);
    chk("rst_notify", {31'd0, res_out_notify}, 32'd0);
    chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b1;
    res_out_sync = 1'b1;

    // Single word latency: E0 push, E1 pop, E2 result, E3 consumed
    send_word(32'd5);
    tick();
    chk("single_e1_notify", {31'd0, res_out_notify}, 32'd0);
    tick();
    chk("single_m_in", m_in, 32'd6);
    chk("single_res", res_out, 32'd5);
    chk("single_notify", {31'd0, res_out_notify}, 32'd1);
    tick();
    chk("single_e3_notify", {31'd0, res_out_notify}, 32'd0);
    chk("single_drop", {24'd0, drop_cnt}, 32'd0);

    // Spaced words accumulate
    do_reset();
    send_word(32'd10); tick(); tick();
    chk("seq0_res", res_out, 32'd10); chk("seq0_m_in", m_in, 32'd11); tick();
    send_word(32'd20); tick(); tick();
    chk("seq1_res", res_out, 32'd30); chk("seq1_m_in", m_in, 32'd21); tick();
    send_word(32'd30); tick(); tick();
    chk("seq2_res", res_out, 32'd60); chk("seq2_m_in", m_in, 32'd31); tick();

    // Backpressure: 6 back-to-back words, one in SEND, four buffered, one dropped
    do_reset();
    res_out_sync = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      m_out = 32'(i);
      m_out_notify = 1'b1;
      tick();
    end
    m_out_notify = 1'b0;
    chk("bp_drop", {24'd0, drop_cnt}, 32'd1);
    chk("bp_ovf", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 14; i++) tick();
    chk("bp_hold_res", res_out, 32'd1);
    chk("bp_hold_notify", {31'd0, res_out_notify}, 32'd1);
    res_out_sync = 1'b1;
    exp_res[0] = 32'd1; exp_res[1] = 32'd3; exp_res[2] = 32'd6;
    exp_res[3] = 32'd10; exp_res[4] = 32'd15;
    for (int k = 0; k < 5; k++) collect($sformatf("bp_res%0d", k), exp_res[k]);
    chk("bp_drop_end", {24'd0, drop_cnt}, 32'd1);
    chk("bp_m_in_end", m_in, 32'd6);

    // Push on the same edge the full FIFO is popped: no drop
    do_reset();
    res_out_sync = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      m_out = 32'(100 * i);
      m_out_notify = 1'b1;
      tick();
    end
    m_out_notify = 1'b0;
    tick(); tick();
    chk("full_first_res", res_out, 32'd100);
    res_out_sync = 1'b1;
    tick();
    send_word(32'd600);
    chk("full_pp_drop", {24'd0, drop_cnt}, 32'd0);
    chk("full_pp_ovf", {31'd0, overflow}, 32'd0);
    exp_fill[0] = 32'd300; exp_fill[1] = 32'd600; exp_fill[2] = 32'd1000;
    exp_fill[3] = 32'd1500; exp_fill[4] = 32'd2100;
    for (int k = 0; k < 5; k++) collect($sformatf("full_res%0d", k), exp_fill[k]);
    chk("full_m_in_end", m_in, 32'd601);

    // Signed overflow boundary
    do_reset();
    send_word(32'h7FFF_FFFF); tick(); tick();
    chk("wrap0_res", res_out, 32'h7FFF_FFFF);
`ifdef MS13_RESPONDER_SATURATE_EN
    chk("wrap0_m_in", m_in, 32'h7FFF_FFFF);
`else
    chk("wrap0_m_in", m_in, 32'h8000_0000);
`endif
    tick();
    send_word(32'd1); tick(); tick();
`ifdef MS13_RESPONDER_SATURATE_EN
    chk("wrap1_res", res_out, 32'h7FFF_FFFF);
`else
    chk("wrap1_res", res_out, 32'h8000_0000);
`endif
    chk("wrap1_m_in", m_in, 32'd2);
    tick();

    // Asynchronous reset while SEND is pending and words are buffered
    do_reset();
    res_out_sync = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      m_out = 32'(i);
      m_out_notify = 1'b1;
      tick();
    end
    m_out_notify = 1'b0;
    chk("ar_pre_drop", {24'd0, drop_cnt}, 32'd1);
    chk("ar_pre_m_in", m_in, 32'd2);
    #2 rst = 1'b0;
    #1;
    chk("ar_notify", {31'd0, res_out_notify}, 32'd0);
    chk("ar_m_in", m_in, 32'd0);
    chk("ar_drop", {24'd0, drop_cnt}, 32'd0);
    chk("ar_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    res_out_sync = 1'b1;
    send_word(32'd7); tick(); tick();
    chk("ar_new_res", res_out, 32'd7);
    chk("ar_new_m_in", m_in, 32'd8);
    tick();
    for (int i = 0; i < 4; i++) tick();
    chk("ar_fifo_lost", {31'd0, res_out_notify}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
